// File: rtl/disp_scan_mux.sv
// disp_scan_mux: time-multiplexed scanner for a common-anode multi-digit
// 7-segment display. It steps one digit per REFRESH_DIV clocks and presents
// that digit's nibble and active-low enable.
//
// Loaded values are double-buffered in a shadow register. They move to the
// active register only at the frame boundary, which is the tick that wraps
// to digit 0.
//
// Build macro DISP_LZB_EN enables leading-zero blanking. In that build a
// digit k>=1 is dark when digits k..NDIGITS-1 are all zero.
module disp_scan_mux #(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   blank,
    output logic [3:0]             nibble,
    output logic [NDIGITS-1:0]     an_n,
    output logic [2:0]             digit_idx,
    output logic                   frame_tick,
    output logic                   pending
);
    localparam int              VW         = 4 * NDIGITS;
    localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [2:0]      IDX_LAST   = 3'(NDIGITS - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [2:0]         idx_q, idx_d;
    logic [VW-1:0]      active_q, active_d;
    logic [VW-1:0]      shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic [3:0]         nibble_q, nibble_d;
    logic [NDIGITS-1:0] an_n_q, an_n_d;
    logic               frame_tick_q, frame_tick_d;
    logic               tick;
    logic               boundary;
    logic [2:0]         idx_next;

    function automatic logic [3:0] pick_nibble(input logic [VW-1:0] v, input logic [2:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (k == 3'(i)) n = v[4*i +: 4];
        end
        return n;
    endfunction

`ifdef DISP_LZB_EN
    // True when slot k (k>=1) and every more significant digit are zero.
    function automatic logic leading_zero(input logic [VW-1:0] v, input logic [2:0] k);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (3'(i) >= k) nz = nz | (|v[4*i +: 4]);
        end
        return (k != 3'd0) && !nz;
    endfunction
`endif

    // Next-state: prescaler, scan index, double buffer and registered outputs.
    always_comb begin
        tick         = (presc_q == PRESC_LAST);
        idx_next     = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        boundary     = tick && (idx_q == IDX_LAST);
        presc_d      = tick ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        nibble_d     = nibble_q;
        an_n_d       = an_n_q;
        frame_tick_d = boundary;

        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
        // A load coincident with the boundary bypasses the shadow entirely.
        if (boundary) begin
            if (load)           active_d = value;
            else if (pending_q) active_d = shadow_q;
            pending_d = 1'b0;
        end

        // active_d already carries the boundary bypass, so digit 0 shows the new value.
        if (tick) begin
            idx_d    = idx_next;
            nibble_d = pick_nibble(active_d, idx_next);
            an_n_d   = '1;
            if (!blank) begin
                for (int i = 0; i < NDIGITS; i++) begin
                    an_n_d[i] = (idx_next != 3'(i));
                end
`ifdef DISP_LZB_EN
                if (leading_zero(active_d, idx_next)) an_n_d = '1;
`endif
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= IDX_LAST;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'd0;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign nibble     = nibble_q;
    assign an_n       = an_n_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux with NDIGITS=4 and REFRESH_DIV=4.
// The reference model derives each slot from the count of rising edges
// since reset release. Directed literals pin that model.
module tb_disp_scan_mux;
    localparam int N  = 4;
    localparam int RD = 4;
    localparam int W  = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic         blank;
    logic [W-1:0] value;
    logic [3:0]   nibble;
    logic [N-1:0] an_n;
    logic [2:0]   digit_idx;
    logic         frame_tick;
    logic         pending;

    int checks = 0;
    int errors = 0;

    disp_scan_mux #(.NDIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank      (blank),
        .nibble     (nibble),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Slot s (s>=1) starts on edge s*RD and shows digit (s-1)%N.
    int           m_edges  = 0;
    logic [W-1:0] m_active = '0;
    logic [W-1:0] m_shadow = '0;
    logic         m_pend   = 1'b0;
    logic         m_ft     = 1'b0;
    logic [3:0]   m_nib    = 4'd0;
    logic [N-1:0] m_an     = '1;
    logic [2:0]   m_idx    = 3'(N - 1);

    initial begin : model
        int d;
        logic [W-1:0] sh;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_edges  = 0;
                m_active = '0;
                m_shadow = '0;
                m_pend   = 1'b0;
                m_ft     = 1'b0;
                m_nib    = 4'd0;
                m_an     = '1;
                m_idx    = 3'(N - 1);
            end else begin
                m_edges++;
                m_ft = 1'b0;
                if (m_edges % RD == 0) begin
                    d = (m_edges / RD - 1) % N;
                    if (d == 0) begin
                        if (load)        m_active = value;
                        else if (m_pend) m_active = m_shadow;
                        m_pend = 1'b0;
                        m_ft   = 1'b1;
                    end else if (load) begin
                        m_shadow = value;
                        m_pend   = 1'b1;
                    end
                    sh    = m_active >> (4 * d);
                    m_nib = sh[3:0];
                    m_idx = 3'(d);
                    m_an  = '1;
                    if (!blank) m_an[d] = 1'b0;
`ifdef DISP_LZB_EN
                    if (d != 0 && sh == '0) m_an = '1;
`endif
                end else if (load) begin
                    m_shadow = value;
                    m_pend   = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("m_nibble",  32'(nibble),     32'(m_nib));
                chk("m_an_n",    32'(an_n),       32'(m_an));
                chk("m_idx",     32'(digit_idx),  32'(m_idx));
                chk("m_ftick",   32'(frame_tick), 32'(m_ft));
                chk("m_pending", 32'(pending),    32'(m_pend));
            end
        end
    end

    task automatic goto_edge(input int e);
        int guard;
        guard = 0;
        while (m_edges != e && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (m_edges != e) begin
            checks++;
            errors++;
            $display("FAIL goto_edge: reached %0d expected %0d", m_edges, e);
        end
    endtask

    task automatic expect_slot(input string tag, input int nib, input int an, input int idx);
        chk({tag, "_nib"}, 32'(nibble),    nib);
        chk({tag, "_an"},  32'(an_n),      an);
        chk({tag, "_idx"}, 32'(digit_idx), idx);
    endtask

    initial begin : stim
        rst_n = 1'b0;
        load  = 1'b0;
        blank = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        expect_slot("rst", 0, 'hF, 3);
        chk("rst_ft",   32'(frame_tick), 0);
        chk("rst_pend", 32'(pending),    0);
        rst_n = 1'b1;

        for (int e = 1; e <= 3; e++) begin
            goto_edge(e);
            expect_slot("pre", 0, 'hF, 3);
        end
        goto_edge(4);  expect_slot("first", 0, 'hE, 0); chk("first_ft", 32'(frame_tick), 1);
        goto_edge(5);  chk("first_ft_drop", 32'(frame_tick), 0);
        goto_edge(8);  expect_slot("s1", 0, 'hD, 1);
        goto_edge(12); expect_slot("s2", 0, 'hB, 2);
        goto_edge(16); expect_slot("s3", 0, 'h7, 3);
        goto_edge(20); expect_slot("s0b", 0, 'hE, 0); chk("s0b_ft", 32'(frame_tick), 1);

        // Mid-frame load waits for the boundary.
        goto_edge(25); load = 1'b1; value = 16'h1A2F;
        goto_edge(26); load = 1'b0; chk("ld_pend", 32'(pending), 1);
        goto_edge(28); expect_slot("ld_old", 0, 'hB, 2);
        goto_edge(36); expect_slot("ld_d0", 'hF, 'hE, 0); chk("ld_pend_clr", 32'(pending), 0);
        goto_edge(40); expect_slot("ld_d1", 'h2, 'hD, 1);
        goto_edge(44); expect_slot("ld_d2", 'hA, 'hB, 2);
        goto_edge(48); expect_slot("ld_d3", 'h1, 'h7, 3);

        // Last load in a frame wins.
        goto_edge(54); load = 1'b1; value = 16'h1111;
        goto_edge(55); load = 1'b0;
        goto_edge(58); load = 1'b1; value = 16'h2222;
        goto_edge(59); load = 1'b0;
        goto_edge(68); expect_slot("dbl_d0", 2, 'hE, 0);
        goto_edge(72); expect_slot("dbl_d1", 2, 'hD, 1);
        goto_edge(76); expect_slot("dbl_d2", 2, 'hB, 2);
        goto_edge(80); expect_slot("dbl_d3", 2, 'h7, 3);

        // Load coincident with the boundary tick goes straight out.
        goto_edge(83); load = 1'b1; value = 16'hBEEF;
        goto_edge(84); load = 1'b0;
        expect_slot("byp_d0", 'hF, 'hE, 0);
        chk("byp_pend", 32'(pending), 0);
        goto_edge(85); chk("byp_pend2", 32'(pending), 0);
        goto_edge(88); expect_slot("byp_d1", 'hE, 'hD, 1);
        goto_edge(96); expect_slot("byp_d3", 'hB, 'h7, 3);

        // Blank for one frame.
        goto_edge(99); blank = 1'b1;
        goto_edge(100); expect_slot("blk_d0", 'hF, 'hF, 0); chk("blk_ft", 32'(frame_tick), 1);
        goto_edge(104); expect_slot("blk_d1", 'hE, 'hF, 1);
        goto_edge(108); expect_slot("blk_d2", 'hE, 'hF, 2);
        goto_edge(112); expect_slot("blk_d3", 'hB, 'hF, 3);
        goto_edge(113); blank = 1'b0;
        goto_edge(116); expect_slot("unblk", 'hF, 'hE, 0);

        // Leading zeros (blanked only in the DISP_LZB_EN build).
        goto_edge(117); load = 1'b1; value = 16'h0050;
        goto_edge(118); load = 1'b0;
        goto_edge(132); expect_slot("lz_d0", 0, 'hE, 0);
        goto_edge(136); expect_slot("lz_d1", 5, 'hD, 1);
`ifdef DISP_LZB_EN
        goto_edge(140); expect_slot("lz_d2", 0, 'hF, 2);
        goto_edge(144); expect_slot("lz_d3", 0, 'hF, 3);
`else
        goto_edge(140); expect_slot("lz_d2", 0, 'hB, 2);
        goto_edge(144); expect_slot("lz_d3", 0, 'h7, 3);
`endif
        goto_edge(145); load = 1'b1; value = 16'h0000;
        goto_edge(146); load = 1'b0;
        goto_edge(148); expect_slot("z_d0", 0, 'hE, 0);
`ifdef DISP_LZB_EN
        goto_edge(152); expect_slot("z_d1", 0, 'hF, 1);
`else
        goto_edge(152); expect_slot("z_d1", 0, 'hD, 1);
`endif

        // Asynchronous reset mid-frame with a load pending.
        goto_edge(165); load = 1'b1; value = 16'h9999;
        goto_edge(166); load = 1'b0;
        goto_edge(180); expect_slot("pre_rst", 9, 'hE, 0);
        goto_edge(182); load = 1'b1; value = 16'h7777;
        goto_edge(183); load = 1'b0; chk("pre_rst_pend", 32'(pending), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_slot("arst", 0, 'hF, 3);
        chk("arst_ft",   32'(frame_tick), 0);
        chk("arst_pend", 32'(pending),    0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        goto_edge(4);  expect_slot("post_d0", 0, 'hE, 0); chk("post_ft", 32'(frame_tick), 1);
        goto_edge(8);  expect_slot("post_d1", 0, 'hD, 1);
        goto_edge(20); expect_slot("post_f2", 0, 'hE, 0); chk("post_pend", 32'(pending), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
